// File: rtl/qid_lq_accumulator.sv
// Merges located chunks of one logical instruction into a full-width per-LQ word and buffers
// completed words in a small valid/ready FIFO. Optional LQ-conflict check: QID_ACC_CONFLICT_CHK_EN.
module qid_lq_accumulator #(
  parameter int unsigned         NUM_LQ         = 16,
  parameter int unsigned         OPCODE_BW      = 5,
  parameter int unsigned         LQADDR_BW      = 4,
  parameter int unsigned         MAX_CHUNKS     = 2,
  parameter int unsigned         OUT_DEPTH      = 2,
  parameter logic [OPCODE_BW-1:0] INVALID_OPCODE = '1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_last,
  input  logic [NUM_LQ*OPCODE_BW-1:0]   in_opcode_loc,
  input  logic [NUM_LQ*LQADDR_BW-1:0]   in_mregdst_loc,
  input  logic [NUM_LQ*2-1:0]           in_lpplist_loc,
  input  logic [NUM_LQ-1:0]             in_lqlist_loc,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NUM_LQ*OPCODE_BW-1:0]   out_opcode,
  output logic [NUM_LQ*LQADDR_BW-1:0]   out_mregdst,
  output logic [NUM_LQ*2-1:0]           out_lpplist,
  output logic [NUM_LQ-1:0]             out_lqlist,
  output logic                          err_overrun,
  output logic                          err_conflict
);

  localparam int unsigned OpW  = NUM_LQ * OPCODE_BW;
  localparam int unsigned MrW  = NUM_LQ * LQADDR_BW;
  localparam int unsigned LpW  = NUM_LQ * 2;
  localparam int unsigned PtrW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int unsigned FcW  = PtrW + 1;
  localparam int unsigned CntW = $clog2(MAX_CHUNKS) + 1;

  localparam logic [OpW-1:0]  OpRst    = {NUM_LQ{INVALID_OPCODE}};
  localparam logic [PtrW-1:0] PtrOne   = PtrW'(1);
  localparam logic [FcW-1:0]  FcOne    = FcW'(1);
  localparam logic [FcW-1:0]  FifoFull = FcW'(OUT_DEPTH);
  localparam logic [CntW-1:0] CntOne   = CntW'(1);
  localparam logic [CntW-1:0] LastCnt  = CntW'(MAX_CHUNKS - 1);

  typedef enum logic [0:0] {StIdle, StAccum} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] chunk_cnt_q, chunk_cnt_d;
  logic [OpW-1:0]  acc_op_q, acc_op_d;
  logic [MrW-1:0]  acc_mr_q, acc_mr_d;
  logic [LpW-1:0]  acc_lp_q, acc_lp_d;
  logic [NUM_LQ-1:0] acc_lq_q, acc_lq_d;

  logic [OpW-1:0]    mrg_op;
  logic [MrW-1:0]    mrg_mr;
  logic [LpW-1:0]    mrg_lp;
  logic [NUM_LQ-1:0] mrg_lq;

  logic [OpW-1:0]    mem_op_q [OUT_DEPTH];
  logic [MrW-1:0]    mem_mr_q [OUT_DEPTH];
  logic [LpW-1:0]    mem_lp_q [OUT_DEPTH];
  logic [NUM_LQ-1:0] mem_lq_q [OUT_DEPTH];

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FcW-1:0]  fifo_cnt_q, fifo_cnt_d;

  logic fifo_full, pop, accept, at_limit, push, overrun_set;
  logic err_overrun_q;

  // Per-LQ merge of the incoming chunk over the running accumulation.
  always_comb begin
    mrg_op = acc_op_q;
    mrg_mr = acc_mr_q;
    mrg_lp = acc_lp_q;
    mrg_lq = acc_lq_q;
    for (int unsigned i = 0; i < NUM_LQ; i++) begin
      if (in_lqlist_loc[i]) begin
        mrg_op[i*OPCODE_BW +: OPCODE_BW] = in_opcode_loc[i*OPCODE_BW +: OPCODE_BW];
        mrg_mr[i*LQADDR_BW +: LQADDR_BW] = in_mregdst_loc[i*LQADDR_BW +: LQADDR_BW];
        mrg_lp[i*2 +: 2]                 = in_lpplist_loc[i*2 +: 2];
        mrg_lq[i]                        = 1'b1;
      end
    end
  end

  always_comb begin
    fifo_full   = (fifo_cnt_q == FifoFull);
    out_valid   = (fifo_cnt_q != '0);
    pop         = out_valid && out_ready;
    in_ready    = !fifo_full || pop;
    accept      = in_valid && in_ready;
    at_limit    = (chunk_cnt_q == LastCnt);
    // Hitting the chunk limit without in_last forces a flush.
    push        = accept && (in_last || at_limit);
    overrun_set = accept && !in_last && at_limit;
  end

  always_comb begin
    state_d     = state_q;
    chunk_cnt_d = chunk_cnt_q;
    acc_op_d    = acc_op_q;
    acc_mr_d    = acc_mr_q;
    acc_lp_d    = acc_lp_q;
    acc_lq_d    = acc_lq_q;
    if (accept) begin
      if (push) begin
        state_d     = StIdle;
        chunk_cnt_d = '0;
        acc_op_d    = OpRst;
        acc_mr_d    = '0;
        acc_lp_d    = '0;
        acc_lq_d    = '0;
      end else begin
        unique case (state_q)
          StIdle:  state_d = StAccum;
          StAccum: state_d = StAccum;
          default: state_d = StIdle;
        endcase
        chunk_cnt_d = chunk_cnt_q + CntOne;
        acc_op_d    = mrg_op;
        acc_mr_d    = mrg_mr;
        acc_lp_d    = mrg_lp;
        acc_lq_d    = mrg_lq;
      end
    end
  end

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + PtrOne : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PtrOne : rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    unique case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + FcOne;
      2'b01:   fifo_cnt_d = fifo_cnt_q - FcOne;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      chunk_cnt_q   <= '0;
      acc_op_q      <= OpRst;
      acc_mr_q      <= '0;
      acc_lp_q      <= '0;
      acc_lq_q      <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      fifo_cnt_q    <= '0;
      err_overrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      chunk_cnt_q   <= chunk_cnt_d;
      acc_op_q      <= acc_op_d;
      acc_mr_q      <= acc_mr_d;
      acc_lp_q      <= acc_lp_d;
      acc_lq_q      <= acc_lq_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      fifo_cnt_q    <= fifo_cnt_d;
      err_overrun_q <= err_overrun_q | overrun_set;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < OUT_DEPTH; k++) begin
        mem_op_q[k] <= OpRst;
        mem_mr_q[k] <= '0;
        mem_lp_q[k] <= '0;
        mem_lq_q[k] <= '0;
      end
    end else if (push) begin
      mem_op_q[wr_ptr_q] <= mrg_op;
      mem_mr_q[wr_ptr_q] <= mrg_mr;
      mem_lp_q[wr_ptr_q] <= mrg_lp;
      mem_lq_q[wr_ptr_q] <= mrg_lq;
    end
  end

  assign out_opcode  = mem_op_q[rd_ptr_q];
  assign out_mregdst = mem_mr_q[rd_ptr_q];
  assign out_lpplist = mem_lp_q[rd_ptr_q];
  assign out_lqlist  = mem_lq_q[rd_ptr_q];
  assign err_overrun = err_overrun_q;

`ifdef QID_ACC_CONFLICT_CHK_EN
  logic err_conflict_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_conflict_q <= 1'b0;
    end else if (accept && |(in_lqlist_loc & acc_lq_q)) begin
      err_conflict_q <= 1'b1;
    end
  end

  assign err_conflict = err_conflict_q;
`else
  assign err_conflict = 1'b0;
`endif

endmodule

// File: tb/tb_qid_lq_accumulator.sv
// Directed scoreboard bench for qid_lq_accumulator; honours QID_ACC_CONFLICT_CHK_EN like the DUT.
module tb_qid_lq_accumulator;

  localparam int unsigned NUM_LQ     = 16;
  localparam int unsigned OPCODE_BW  = 5;
  localparam int unsigned LQADDR_BW  = 4;
  localparam int unsigned MAX_CHUNKS = 2;
  localparam int unsigned OUT_DEPTH  = 2;
  localparam logic [OPCODE_BW-1:0] INV = 5'h1F;

`ifdef QID_ACC_CONFLICT_CHK_EN
  localparam logic CONF_EXP = 1'b1;
`else
  localparam logic CONF_EXP = 1'b0;
`endif

  typedef struct packed {
    logic [NUM_LQ*OPCODE_BW-1:0] op;
    logic [NUM_LQ*LQADDR_BW-1:0] mr;
    logic [NUM_LQ*2-1:0]         lp;
    logic [NUM_LQ-1:0]           lq;
  } word_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0, in_ready, in_last = 1'b0;
  logic [NUM_LQ*OPCODE_BW-1:0] in_opcode_loc = '1;
  logic [NUM_LQ*LQADDR_BW-1:0] in_mregdst_loc = '0;
  logic [NUM_LQ*2-1:0]         in_lpplist_loc = '0;
  logic [NUM_LQ-1:0]           in_lqlist_loc = '0;
  logic out_valid, out_ready = 1'b1;
  logic [NUM_LQ*OPCODE_BW-1:0] out_opcode;
  logic [NUM_LQ*LQADDR_BW-1:0] out_mregdst;
  logic [NUM_LQ*2-1:0]         out_lpplist;
  logic [NUM_LQ-1:0]           out_lqlist;
  logic err_overrun, err_conflict;

  qid_lq_accumulator #(
    .NUM_LQ(NUM_LQ), .OPCODE_BW(OPCODE_BW), .LQADDR_BW(LQADDR_BW),
    .MAX_CHUNKS(MAX_CHUNKS), .OUT_DEPTH(OUT_DEPTH), .INVALID_OPCODE(INV)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .in_opcode_loc(in_opcode_loc), .in_mregdst_loc(in_mregdst_loc),
    .in_lpplist_loc(in_lpplist_loc), .in_lqlist_loc(in_lqlist_loc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_mregdst(out_mregdst),
    .out_lpplist(out_lpplist), .out_lqlist(out_lqlist),
    .err_overrun(err_overrun), .err_conflict(err_conflict)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  word_t exp_q[$];
  word_t mdl_acc;

  function automatic word_t rst_word();
    word_t w;
    w.op = {NUM_LQ{INV}};
    w.mr = '0;
    w.lp = '0;
    w.lq = '0;
    return w;
  endfunction

  // Untargeted LQs carry junk mregdst/lpp that the DUT must ignore.
  function automatic word_t make_chunk(input logic [NUM_LQ-1:0] mask,
                                       input logic [OPCODE_BW-1:0] op,
                                       input logic [LQADDR_BW-1:0] mr,
                                       input logic [1:0] lp);
    word_t w;
    logic [31:0] junk;
    w.lq = mask;
    for (int i = 0; i < NUM_LQ; i++) begin
      junk = $urandom;
      w.op[i*OPCODE_BW +: OPCODE_BW] = mask[i] ? op : INV;
      w.mr[i*LQADDR_BW +: LQADDR_BW] = mask[i] ? mr : junk[3:0];
      w.lp[i*2 +: 2]                 = mask[i] ? lp : junk[5:4];
    end
    return w;
  endfunction

  function automatic word_t merge(input word_t acc, input word_t ch);
    word_t w;
    w = acc;
    for (int i = 0; i < NUM_LQ; i++) begin
      if (ch.lq[i]) begin
        w.op[i*OPCODE_BW +: OPCODE_BW] = ch.op[i*OPCODE_BW +: OPCODE_BW];
        w.mr[i*LQADDR_BW +: LQADDR_BW] = ch.mr[i*LQADDR_BW +: LQADDR_BW];
        w.lp[i*2 +: 2]                 = ch.lp[i*2 +: 2];
        w.lq[i]                        = 1'b1;
      end
    end
    return w;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic word_t dut_word();
    word_t w;
    w.op = out_opcode;
    w.mr = out_mregdst;
    w.lp = out_lpplist;
    w.lq = out_lqlist;
    return w;
  endfunction

  // Sample on the falling edge, then advance to just after the next rising edge.
  task automatic tick();
    word_t e;
    @(negedge clk);
    chk("out_valid_vs_model", out_valid, exp_q.size() != 0);
    if (out_valid && out_ready && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("scoreboard_word", dut_word(), e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic accept_model(input word_t ch, input bit push_exp);
    mdl_acc = merge(mdl_acc, ch);
    if (push_exp) begin
      exp_q.push_back(mdl_acc);
      mdl_acc = rst_word();
    end
  endtask

  task automatic drive(input word_t ch, input bit last);
    in_valid       = 1'b1;
    in_last        = last;
    in_opcode_loc  = ch.op;
    in_mregdst_loc = ch.mr;
    in_lpplist_loc = ch.lp;
    in_lqlist_loc  = ch.lq;
  endtask

  task automatic send(input word_t ch, input bit last, input bit push_exp);
    int n;
    drive(ch, last);
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    chk("in_ready_wait", in_ready, 1'b1);
    tick();
    accept_model(ch, push_exp);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    tick();
    chk("drained", out_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    word_t ch, ch3;
    mdl_acc = rst_word();

    // Reset state
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_err_overrun", err_overrun, 1'b0);
    chk("rst_err_conflict", err_conflict, 1'b0);
    chk("rst_out_lqlist", out_lqlist, 16'h0000);
    chk("rst_out_opcode", out_opcode, {NUM_LQ{INV}});

    // Single chunk: X on LQ0, Z on LQ2
    ch = make_chunk(16'h0005, 5'h03, 4'h6, 2'b01);
    ch.lp[5:4] = 2'b11;
    send(ch, 1'b1, 1'b1);
    chk("single_out_valid", out_valid, 1'b1);
    chk("single_lqlist", out_lqlist, 16'h0005);
    chk("single_op_lq0", out_opcode[4:0], 5'h03);
    chk("single_op_lq1", out_opcode[9:5], INV);
    chk("single_op_lq2", out_opcode[14:10], 5'h03);
    chk("single_mr_lq1", out_mregdst[7:4], 4'h0);
    chk("single_lp", out_lpplist[5:0], 6'b110001);
    drain();

    // Two chunks merge into one word
    send(make_chunk(16'h0003, 5'h01, 4'h2, 2'b01), 1'b0, 1'b0);
    chk("two_no_word_yet", out_valid, 1'b0);
    send(make_chunk(16'h0300, 5'h04, 4'h5, 2'b10), 1'b1, 1'b1);
    chk("two_lqlist", out_lqlist, 16'h0303);
    chk("two_op_lq8", out_opcode[44:40], 5'h04);
    chk("two_op_lq2", out_opcode[14:10], INV);
    drain();

    // Backpressure: fill the FIFO, hold a third chunk, then release
    out_ready = 1'b0;
    send(make_chunk(16'h0010, 5'h07, 4'h1, 2'b11), 1'b1, 1'b1);
    send(make_chunk(16'h0020, 5'h09, 4'h3, 2'b01), 1'b1, 1'b1);
    chk("bp_full_in_ready", in_ready, 1'b0);
    chk("bp_out_valid", out_valid, 1'b1);
    ch3 = make_chunk(16'h0040, 5'h0A, 4'h4, 2'b10);
    drive(ch3, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bp_hold_ready", in_ready, 1'b0);
      chk("bp_stable", dut_word(), exp_q[0]);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_ready_comb", in_ready, 1'b1);
    tick();
    accept_model(ch3, 1'b1);
    in_valid = 1'b0;
    drain();

    // Overrun: second non-last chunk is forced out
    send(make_chunk(16'h0100, 5'h0B, 4'h7, 2'b01), 1'b0, 1'b0);
    chk("ovr_before", err_overrun, 1'b0);
    send(make_chunk(16'h0200, 5'h0C, 4'h8, 2'b10), 1'b0, 1'b1);
    chk("ovr_set", err_overrun, 1'b1);
    drain();
    chk("ovr_sticky", err_overrun, 1'b1);

    // Same LQ targeted twice; the later chunk wins
    chk("conf_before", err_conflict, 1'b0);
    send(make_chunk(16'h0001, 5'h06, 4'h7, 2'b01), 1'b0, 1'b0);
    send(make_chunk(16'h0001, 5'h08, 4'h9, 2'b11), 1'b1, 1'b1);
    chk("conf_flag", err_conflict, CONF_EXP);
    chk("conf_op_lq0", out_opcode[4:0], 5'h08);
    chk("conf_mr_lq0", out_mregdst[3:0], 4'h9);
    drain();

    // Reset mid-operation discards buffered and partial state
    out_ready = 1'b0;
    send(make_chunk(16'h0400, 5'h0D, 4'hA, 2'b01), 1'b1, 1'b1);
    send(make_chunk(16'h0800, 5'h0E, 4'hB, 2'b10), 1'b0, 1'b0);
    chk("mid_buffered", out_valid, 1'b1);
    rst = 1'b1;
    tick();
    exp_q.delete();
    mdl_acc = rst_word();
    rst = 1'b0;
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_overrun", err_overrun, 1'b0);
    chk("mid_rst_conflict", err_conflict, 1'b0);
    chk("mid_rst_lqlist", out_lqlist, 16'h0000);
    out_ready = 1'b1;
    send(make_chunk(16'h1000, 5'h02, 4'hC, 2'b11), 1'b1, 1'b1);
    chk("post_rst_lqlist", out_lqlist, 16'h1000);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
